ptp_tx_gen: RTL and testbench
=============================

PTP_TX_GEN -- requirements
Module: ptp_tx_gen

Interface
REQ-001 SHALL have parameters: REQ_DEPTH, default 8, max pending requests per type; FIFO_DEPTH, default 64, key and t4 FIFO depth; CYC_MOD, default 125000, cycles per ms field wrap; RTT_CORR, default 17'h9C, RTT correction in cycles.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset. Reset is asynchronous and active-high. Only one clock.
REQ-003 SHALL have ports: cyc_timer in 48 {ms[47:17],cyc[16:0]}; mac_addr in 48 local MAC.
REQ-004 SHALL have ports: send_sync, send_dreq, send_dresp, send_test, each in 1, a one-cycle request pulse.
REQ-005 SHALL have ports: key in 54 {dmac[53:6],port[5:0]}; key_valid in 1; ts_4 in 48; ts_4_valid in 1.
REQ-006 SHALL have ports: outtx_data_wr out 1; outtx_data out 134; outtx_valid_wr out 1; outtx_valid out 1; outtx_ready in 1.
REQ-007 SHALL have ports: ts_3_valid out 1; ts_3 out 48; ptp_send_type out 4; ptp_send_type_valid out 1; rtt_time out 48; drop_cnt out 16; seq_sync, seq_dreq, seq_dresp out 16 each.

Function
REQ-008 SHALL hold one saturating pending counter per type, of width clog2(REQ_DEPTH+1). A request pulse increments it; a grant decrements it.
REQ-009 SHALL leave the counter unchanged when a request and a grant hit the same type in the same cycle; this SHALL NOT count as a drop.
REQ-010 SHALL, on a request to a counter already at REQ_DEPTH with no same-cycle grant, discard the request and increment drop_cnt, which saturates at 16'hFFFF.
REQ-011 SHALL buffer key and ts_4 in FIFOs of depth FIFO_DEPTH. A write to a full FIFO is dropped and increments drop_cnt.
REQ-012 SHALL arbitrate only in IDLE with outtx_ready=1, using fixed priority sync > dreq > dresp > test.
REQ-013 SHALL grant dreq only when the key FIFO is non-empty. SHALL grant dresp only when both the key FIFO and the t4 FIFO are non-empty.
REQ-014 SHALL use the states IDLE, META1, HDR, PTP0, PTP1, TAIL. Each state emits one beat; all states advance unconditionally; TAIL returns to IDLE. A packet is 6 beats on consecutive cycles.
REQ-015 SHALL write metadata word 0 in the grant cycle, with fields:
- [133:128]=6'b010000, [127]=1;
- ingress/outport = 6'b111111 for sync, key port for dreq/dresp, 0 for test;
- pkt_length=92, src/dst module id 4/5;
- [47:0] = cyc_timer latched as tstamp.
REQ-016 SHALL write META1 as {6'b110000,128'd0}.
REQ-017 SHALL write HDR as {6'b110000, dst, mac_addr, 16'h88F7, 16'h0m01}. m is 1/3/4/5 for sync/dreq/dresp/test. dst is broadcast for sync, key dmac for dreq/dresp, and {32'h12345678, mac_addr[15:0]} for test.
REQ-018 SHALL write PTP0 as {6'b110000, 16'h0030, 96'd0, seq}, where seq is that type's counter value. The counter increments after the TAIL beat; test uses seq 0.
REQ-019 SHALL write PTP1 as {6'b110000,128'd0}.
REQ-020 SHALL write TAIL as {6'b100100, 32'd0, T, 48'd0}. T is the popped t4 for dresp and tstamp otherwise.
REQ-021 SHALL pop the key FIFO (dreq/dresp) and the t4 FIFO (dresp) exactly once per packet, latching data before HDR.
REQ-022 SHALL pulse ts_3_valid in the dreq grant cycle with ts_3=tstamp.
REQ-023 SHALL pulse outtx_valid_wr=outtx_valid=1 in the TAIL cycle.
REQ-024 SHALL, in the TAIL cycle, pulse ptp_send_type_valid with ptp_send_type 1, 3 or 4 for sync/dreq/dresp; SHALL NOT pulse it for test.
REQ-025 SHALL return all pulse outputs to 0 in the cycle after their pulse; outtx_data SHALL be 0 whenever outtx_data_wr=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously force the FSM to IDLE and all outputs, counters, sequence numbers and FIFOs to 0. A packet in flight is truncated with no TAIL.

Configuration
REQ-027 With PTP_TX_RTT_EN defined, the block SHALL:
- latch t1=tstamp at the sync TAIL and t4 at the dresp TAIL;
- one cycle later set rtt_time = t4-t1+RTT_CORR, with cyc computed modulo CYC_MOD and borrow/carry applied to ms.
REQ-028 With PTP_TX_RTT_EN undefined, rtt_time SHALL be tied to 0 and the t1/t4 registers SHALL be absent.

Structure
REQ-029 Package ptp_tx_pkg SHALL hold the state enum, type codes (SYNC=1, DREQ=3, DRESP=4, TEST=5), the header constants (88F7, 0030, module ids, pkt_length) and the metadata field offsets.
REQ-030 There SHALL be one sub-module, ptp_tx_fifo (WIDTH, DEPTH, show-ahead), instantiated twice.

Verification
REQ-031 The bench SHALL cover at least the following scenarios:
- send_sync at cyc_timer=48'h0000_0002_0100 with ready=1: 6 beats; HDR dst FFFFFFFFFFFF; TAIL T=48'h0000_0002_0100; type 1 pulse; seq_sync becomes 1.
- key {dmac 0x001122334455, port 2} then send_dreq: outport 2; ts_3_valid in the grant cycle; ptp_send_type 3.
- send_sync, send_dreq and send_test in the same cycle: packets emitted in the order sync, dreq, test.
- 9 sync pulses while ready=0: drop_cnt=1; after ready rises, exactly 8 sync packets.
- With PTP_TX_RTT_EN: t1.cyc=124990, t4 in the next ms with cyc=10: rtt_time={0,17'd176}.
- rst asserted during PTP0: outputs drop to 0 immediately; no TAIL; the next grant starts with seq 0.

Source files
------------

// File: rtl/ptp_tx_pkg.sv
// Shared types and constants for the PTP transmit generator.
package ptp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META1,
    ST_HDR,
    ST_PTP0,
    ST_PTP1,
    ST_TAIL
  } state_t;

  typedef enum logic [3:0] {
    TYPE_NONE  = 4'd0,
    TYPE_SYNC  = 4'd1,
    TYPE_DREQ  = 4'd3,
    TYPE_DRESP = 4'd4,
    TYPE_TEST  = 4'd5
  } ptp_type_t;

  // Header constants
  localparam logic [15:0] ETH_TYPE_PTP = 16'h88F7;
  localparam logic [15:0] PTP_MSG_LEN  = 16'h0030;
  localparam logic [15:0] PKT_LENGTH   = 16'd92;
  localparam logic [7:0]  SRC_MID      = 8'd4;
  localparam logic [7:0]  DST_MID      = 8'd5;
  localparam logic [5:0]  PORT_BCAST   = 6'b111111;

  // Beat framing tags
  localparam logic [5:0]  TAG_META0    = 6'b010000;
  localparam logic [5:0]  TAG_BODY     = 6'b110000;
  localparam logic [5:0]  TAG_TAIL     = 6'b100100;

  // Metadata word 0 field offsets
  localparam int MD_VALID_BIT   = 127;
  localparam int MD_OUTPORT_LSB = 118;
  localparam int MD_PKTLEN_LSB  = 96;
  localparam int MD_SRCMID_LSB  = 88;
  localparam int MD_DSTMID_LSB  = 80;
  localparam int MD_TSTAMP_LSB  = 0;

  // PTP message word 16'h0m01 for a given type
  function automatic logic [15:0] msg_word(ptp_type_t t);
    return {4'h0, t, 8'h01};
  endfunction

endpackage

// File: rtl/ptp_tx_fifo.sv
// Show-ahead FIFO: rd_data presents the head entry whenever not empty.
module ptp_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] next_ptr(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are qualified by count so it needs no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ptp_tx_gen.sv
// PTP transmit packet generator: arbitrates sync/dreq/dresp/test requests
// and emits a 6-beat packet per grant.
// Optional feature macro: PTP_TX_RTT_EN (round-trip time measurement).
module ptp_tx_gen
  import ptp_tx_pkg::*;
#(
  parameter int          REQ_DEPTH  = 8,
  parameter int          FIFO_DEPTH = 64,
  parameter int          CYC_MOD    = 125000,
  parameter logic [16:0] RTT_CORR   = 17'h9C
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [47:0]  cyc_timer,
  input  logic [47:0]  mac_addr,
  input  logic         send_sync,
  input  logic         send_dreq,
  input  logic         send_dresp,
  input  logic         send_test,
  input  logic [53:0]  key,
  input  logic         key_valid,
  input  logic [47:0]  ts_4,
  input  logic         ts_4_valid,
  output logic         outtx_data_wr,
  output logic [133:0] outtx_data,
  output logic         outtx_valid_wr,
  output logic         outtx_valid,
  input  logic         outtx_ready,
  output logic         ts_3_valid,
  output logic [47:0]  ts_3,
  output logic [3:0]   ptp_send_type,
  output logic         ptp_send_type_valid,
  output logic [47:0]  rtt_time,
  output logic [15:0]  drop_cnt,
  output logic [15:0]  seq_sync,
  output logic [15:0]  seq_dreq,
  output logic [15:0]  seq_dresp
);

  localparam int                PW        = $clog2(REQ_DEPTH + 1);
  localparam logic [PW-1:0]     PEND_MAX  = PW'(REQ_DEPTH);
  localparam logic signed [19:0] CYC_MOD_S = 20'(CYC_MOD);

  state_t       state, state_nxt;
  ptp_type_t    cur_type, gnt_type;
  logic [3:0]   req_vec, gnt_vec, req_drop;
  logic [PW-1:0] pend [4];
  logic         grant;
  logic [2:0]   drop_inc;
  logic [47:0]  tstamp;
  logic [47:0]  key_dmac;
  logic [47:0]  t4_lat;
  logic [53:0]  key_dout;
  logic [47:0]  t4_dout;
  logic         key_empty, key_full, t4_empty, t4_full;
  logic         key_pop, t4_pop;
  logic [47:0]  hdr_dst;
  logic [15:0]  ptp_seq;
  logic [5:0]   meta_port;

  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [2:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [133:0] build_meta0(logic [5:0] port, logic [47:0] ts);
    logic [133:0] m;
    m = '0;
    m[133:128]                = TAG_META0;
    m[MD_VALID_BIT]           = 1'b1;
    m[MD_OUTPORT_LSB +: 6]    = port;
    m[MD_PKTLEN_LSB +: 16]    = PKT_LENGTH;
    m[MD_SRCMID_LSB +: 8]     = SRC_MID;
    m[MD_DSTMID_LSB +: 8]     = DST_MID;
    m[MD_TSTAMP_LSB +: 48]    = ts;
    return m;
  endfunction

  // t4 - t1 + correction with the cycle field wrapping at CYC_MOD
  function automatic logic [47:0] rtt_calc(logic [47:0] t4, logic [47:0] t1);
    logic signed [19:0] c;
    logic [30:0]        ms;
    c  = signed'({3'b000, t4[16:0]}) - signed'({3'b000, t1[16:0]})
         + signed'({3'b000, RTT_CORR});
    ms = t4[47:17] - t1[47:17];
    if (c < 0) begin
      c  = c + CYC_MOD_S;
      ms = ms - 31'd1;
    end else if (c >= CYC_MOD_S) begin
      c  = c - CYC_MOD_S;
      ms = ms + 31'd1;
    end
    return {ms, c[16:0]};
  endfunction

  assign req_vec = {send_test, send_dresp, send_dreq, send_sync};
  assign key_pop = gnt_vec[1] || gnt_vec[2];
  assign t4_pop  = gnt_vec[2];

  ptp_tx_fifo #(.WIDTH(54), .DEPTH(FIFO_DEPTH)) u_key_fifo (
    .clk(clk), .rst(rst), .wr_en(key_valid), .wr_data(key), .rd_en(key_pop),
    .rd_data(key_dout), .empty(key_empty), .full(key_full)
  );

  ptp_tx_fifo #(.WIDTH(48), .DEPTH(FIFO_DEPTH)) u_t4_fifo (
    .clk(clk), .rst(rst), .wr_en(ts_4_valid), .wr_data(ts_4), .rd_en(t4_pop),
    .rd_data(t4_dout), .empty(t4_empty), .full(t4_full)
  );

  // Fixed-priority arbitration, only from IDLE with the sink ready
  always_comb begin
    gnt_vec  = '0;
    gnt_type = TYPE_NONE;
    if (state == ST_IDLE && outtx_ready) begin
      if (pend[0] != '0) begin
        gnt_vec[0] = 1'b1; gnt_type = TYPE_SYNC;
      end else if (pend[1] != '0 && !key_empty) begin
        gnt_vec[1] = 1'b1; gnt_type = TYPE_DREQ;
      end else if (pend[2] != '0 && !key_empty && !t4_empty) begin
        gnt_vec[2] = 1'b1; gnt_type = TYPE_DRESP;
      end else if (pend[3] != '0) begin
        gnt_vec[3] = 1'b1; gnt_type = TYPE_TEST;
      end
    end
  end

  assign grant = |gnt_vec;

  // Requests lost to full pending counters or full FIFOs
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < 4; i++) begin
      req_drop[i] = req_vec[i] && !gnt_vec[i] && (pend[i] == PEND_MAX);
      drop_inc    = drop_inc + 3'(req_drop[i]);
    end
    drop_inc = drop_inc + 3'(key_valid && key_full) + 3'(ts_4_valid && t4_full);
  end

  // Pending request counters; a same-cycle request and grant cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_vec[i] && !gnt_vec[i]) begin
          if (pend[i] != PEND_MAX) pend[i] <= pend[i] + PW'(1);
        end else if (gnt_vec[i] && !req_vec[i]) begin
          pend[i] <= pend[i] - PW'(1);
        end
      end
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= sat_add16(drop_cnt, drop_inc);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: one beat per state, no backpressure once started
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = grant ? ST_META1 : ST_IDLE;
      ST_META1: state_nxt = ST_HDR;
      ST_HDR:   state_nxt = ST_PTP0;
      ST_PTP0:  state_nxt = ST_PTP1;
      ST_PTP1:  state_nxt = ST_TAIL;
      ST_TAIL:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-packet context captured at the grant, including the FIFO pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_type <= TYPE_NONE;
      tstamp   <= '0;
      key_dmac <= '0;
      t4_lat   <= '0;
    end else if (grant) begin
      cur_type <= gnt_type;
      tstamp   <= cyc_timer;
      key_dmac <= key_pop ? key_dout[53:6] : 48'd0;
      t4_lat   <= t4_pop ? t4_dout : 48'd0;
    end
  end

  // Sequence numbers advance once the packet's TAIL has gone out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_sync  <= '0;
      seq_dreq  <= '0;
      seq_dresp <= '0;
    end else if (state == ST_TAIL) begin
      case (cur_type)
        TYPE_SYNC:  seq_sync  <= seq_sync + 16'd1;
        TYPE_DREQ:  seq_dreq  <= seq_dreq + 16'd1;
        TYPE_DRESP: seq_dresp <= seq_dresp + 16'd1;
        default:    ;
      endcase
    end
  end

  // Per-type header field selection
  always_comb begin
    hdr_dst   = 48'd0;
    ptp_seq   = 16'd0;
    meta_port = 6'd0;
    case (cur_type)
      TYPE_SYNC:  begin hdr_dst = 48'hFFFF_FFFF_FFFF; ptp_seq = seq_sync;  end
      TYPE_DREQ:  begin hdr_dst = key_dmac;           ptp_seq = seq_dreq;  end
      TYPE_DRESP: begin hdr_dst = key_dmac;           ptp_seq = seq_dresp; end
      TYPE_TEST:  hdr_dst = {32'h1234_5678, mac_addr[15:0]};
      default:    ;
    endcase
    if (gnt_vec[0])    meta_port = PORT_BCAST;
    else if (key_pop)  meta_port = key_dout[5:0];
  end

  // FSM outputs: the beat for the current state plus side-band pulses
  always_comb begin
    outtx_data_wr       = 1'b0;
    outtx_data          = '0;
    outtx_valid_wr      = 1'b0;
    outtx_valid         = 1'b0;
    ts_3_valid          = 1'b0;
    ts_3                = '0;
    ptp_send_type       = '0;
    ptp_send_type_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          outtx_data_wr = 1'b1;
          outtx_data    = build_meta0(meta_port, cyc_timer);
          if (gnt_vec[1]) begin
            ts_3_valid = 1'b1;
            ts_3       = cyc_timer;
          end
        end
      end
      ST_META1: begin
        outtx_data_wr = 1'b1;
        outtx_data    = {TAG_BODY, 128'd0};
      end
      ST_HDR: begin
        outtx_data_wr = 1'b1;
        outtx_data    = {TAG_BODY, hdr_dst, mac_addr, ETH_TYPE_PTP, msg_word(cur_type)};
      end
      ST_PTP0: begin
        outtx_data_wr = 1'b1;
        outtx_data    = {TAG_BODY, PTP_MSG_LEN, 96'd0, ptp_seq};
      end
      ST_PTP1: begin
        outtx_data_wr = 1'b1;
        outtx_data    = {TAG_BODY, 128'd0};
      end
      ST_TAIL: begin
        outtx_data_wr  = 1'b1;
        outtx_data     = {TAG_TAIL, 32'd0,
                          (cur_type == TYPE_DRESP) ? t4_lat : tstamp, 48'd0};
        outtx_valid_wr = 1'b1;
        outtx_valid    = 1'b1;
        if (cur_type != TYPE_TEST) begin
          ptp_send_type_valid = 1'b1;
          ptp_send_type       = cur_type;
        end
      end
      default: ;
    endcase
  end

`ifdef PTP_TX_RTT_EN
  logic [47:0] t1_p0, t4_p0;
  logic        vld_p0;

  // Stage 0: capture t1 at sync TAIL and t4 at dresp TAIL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_p0  <= '0;
      t4_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (state == ST_TAIL && cur_type == TYPE_SYNC) t1_p0 <= tstamp;
      if (state == ST_TAIL && cur_type == TYPE_DRESP) begin
        t4_p0  <= t4_lat;
        vld_p0 <= 1'b1;
      end
    end
  end

  // Stage 1: round-trip time with cycle-field wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rtt_time <= '0;
    else if (vld_p0) rtt_time <= rtt_calc(t4_p0, t1_p0);
  end
`else
  assign rtt_time = '0;
`endif

endmodule

// File: tb/tb_ptp_tx_gen.sv
// Directed bench for ptp_tx_gen with hand-computed expected beats.
module tb_ptp_tx_gen;

  logic         clk;
  logic         rst;
  logic [47:0]  cyc_timer;
  logic [47:0]  mac_addr;
  logic         send_sync, send_dreq, send_dresp, send_test;
  logic [53:0]  key;
  logic         key_valid;
  logic [47:0]  ts_4;
  logic         ts_4_valid;
  logic         outtx_data_wr;
  logic [133:0] outtx_data;
  logic         outtx_valid_wr, outtx_valid, outtx_ready;
  logic         ts_3_valid;
  logic [47:0]  ts_3;
  logic [3:0]   ptp_send_type;
  logic         ptp_send_type_valid;
  logic [47:0]  rtt_time;
  logic [15:0]  drop_cnt, seq_sync, seq_dreq, seq_dresp;

  int n_cmp = 0;
  int n_err = 0;

  logic [133:0] beat [6];
  logic         bwr  [6];
  logic         bvwr [6];
  logic         bts3v[6];
  logic         bstv [6];
  logic [3:0]   bst  [6];
  logic [47:0]  bts3;
  bit           cap_ok;

  localparam logic [47:0] MAC = 48'h02AA_BBCC_DDEE;

  ptp_tx_gen dut (
    .clk(clk), .rst(rst), .cyc_timer(cyc_timer), .mac_addr(mac_addr),
    .send_sync(send_sync), .send_dreq(send_dreq), .send_dresp(send_dresp),
    .send_test(send_test), .key(key), .key_valid(key_valid), .ts_4(ts_4),
    .ts_4_valid(ts_4_valid), .outtx_data_wr(outtx_data_wr), .outtx_data(outtx_data),
    .outtx_valid_wr(outtx_valid_wr), .outtx_valid(outtx_valid), .outtx_ready(outtx_ready),
    .ts_3_valid(ts_3_valid), .ts_3(ts_3), .ptp_send_type(ptp_send_type),
    .ptp_send_type_valid(ptp_send_type_valid), .rtt_time(rtt_time), .drop_cnt(drop_cnt),
    .seq_sync(seq_sync), .seq_dreq(seq_dreq), .seq_dresp(seq_dresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_req(input bit s, input bit d, input bit r, input bit t);
    send_sync = s; send_dreq = d; send_dresp = r; send_test = t;
    @(posedge clk); #1;
    send_sync = 0; send_dreq = 0; send_dresp = 0; send_test = 0;
  endtask

  task automatic push_key(input logic [53:0] k);
    key = k; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic push_t4(input logic [47:0] t);
    ts_4 = t; ts_4_valid = 1'b1;
    @(posedge clk); #1;
    ts_4_valid = 1'b0;
  endtask

  // Wait (bounded) for a packet start, then record six consecutive beats
  task automatic cap_pkt();
    int w;
    cap_ok = 0;
    w = 0;
    @(negedge clk);
    while (!outtx_data_wr && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (outtx_data_wr) begin
      cap_ok = 1;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge clk);
        beat[k] = outtx_data;   bwr[k]  = outtx_data_wr; bvwr[k] = outtx_valid_wr;
        bts3v[k] = ts_3_valid;  bstv[k] = ptp_send_type_valid; bst[k] = ptp_send_type;
        if (k == 0) bts3 = ts_3;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (outtx_data_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b exp=0", outtx_data_wr); end
    n_cmp++; if (outtx_data !== 134'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", outtx_data); end
    n_cmp++; if ({drop_cnt, seq_sync, seq_dreq, seq_dresp} !== 64'd0) begin n_err++; $display("FAIL reset_counters got=%h exp=0", {drop_cnt, seq_sync, seq_dreq, seq_dresp}); end
    n_cmp++; if (rtt_time !== 48'd0) begin n_err++; $display("FAIL reset_rtt got=%h exp=0", rtt_time); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sync();
    int nwr;
    cyc_timer = 48'h0000_0002_0100;
    pulse_req(1, 0, 0, 0);
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1) begin n_err++; $display("FAIL sync_start got=%b exp=1", cap_ok); end
    nwr = 0;
    for (int k = 0; k < 6; k++) if (bwr[k] === 1'b1) nwr++;
    n_cmp++; if (nwr != 6) begin n_err++; $display("FAIL sync_beats got=%0d exp=6", nwr); end
    n_cmp++; if (beat[0] !== {6'b010000, 1'b1, 3'b0, 6'h3F, 6'b0, 16'd92, 8'd4, 8'd5, 32'd0, 48'h0000_0002_0100}) begin n_err++; $display("FAIL sync_meta0 got=%h", beat[0]); end
    n_cmp++; if (beat[1] !== {6'b110000, 128'd0}) begin n_err++; $display("FAIL sync_meta1 got=%h", beat[1]); end
    n_cmp++; if (beat[2] !== {6'b110000, 48'hFFFF_FFFF_FFFF, MAC, 16'h88F7, 16'h0101}) begin n_err++; $display("FAIL sync_hdr got=%h", beat[2]); end
    n_cmp++; if (beat[3] !== {6'b110000, 16'h0030, 96'd0, 16'd0}) begin n_err++; $display("FAIL sync_ptp0 got=%h", beat[3]); end
    n_cmp++; if (beat[4] !== {6'b110000, 128'd0}) begin n_err++; $display("FAIL sync_ptp1 got=%h", beat[4]); end
    n_cmp++; if (beat[5] !== {6'b100100, 32'd0, 48'h0000_0002_0100, 48'd0}) begin n_err++; $display("FAIL sync_tail got=%h", beat[5]); end
    n_cmp++; if ({bvwr[4], bvwr[5], bstv[4], bstv[5], bst[5]} !== {4'b0101, 4'd1}) begin n_err++; $display("FAIL sync_tail_pulses got=%b exp=0101_0001", {bvwr[4], bvwr[5], bstv[4], bstv[5], bst[5]}); end
    @(negedge clk);
    n_cmp++; if ({outtx_data_wr, outtx_valid_wr, outtx_valid, ptp_send_type_valid} !== 4'b0000 || outtx_data !== 134'd0) begin n_err++; $display("FAIL sync_after_idle got=%b data=%h exp=0", {outtx_data_wr, outtx_valid_wr, outtx_valid, ptp_send_type_valid}, outtx_data); end
    n_cmp++; if (seq_sync !== 16'd1) begin n_err++; $display("FAIL sync_seq got=%0d exp=1", seq_sync); end
  endtask

  task automatic test_dreq();
    push_key({48'h0011_2233_4455, 6'd2});
    cyc_timer = 48'h0000_0003_0007;
    pulse_req(0, 1, 0, 0);
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1) begin n_err++; $display("FAIL dreq_start got=%b exp=1", cap_ok); end
    n_cmp++; if (beat[0] !== {6'b010000, 1'b1, 3'b0, 6'd2, 6'b0, 16'd92, 8'd4, 8'd5, 32'd0, 48'h0000_0003_0007}) begin n_err++; $display("FAIL dreq_meta0 got=%h", beat[0]); end
    n_cmp++; if ({bts3v[0], bts3v[1], bts3v[5]} !== 3'b100 || bts3 !== 48'h0000_0003_0007) begin n_err++; $display("FAIL dreq_ts3 got=%b ts3=%h exp=100 000000030007", {bts3v[0], bts3v[1], bts3v[5]}, bts3); end
    n_cmp++; if (beat[2] !== {6'b110000, 48'h0011_2233_4455, MAC, 16'h88F7, 16'h0301}) begin n_err++; $display("FAIL dreq_hdr got=%h", beat[2]); end
    n_cmp++; if ({bstv[5], bst[5]} !== {1'b1, 4'd3}) begin n_err++; $display("FAIL dreq_type got=%b/%0d exp=1/3", bstv[5], bst[5]); end
    @(negedge clk);
    n_cmp++; if (seq_dreq !== 16'd1) begin n_err++; $display("FAIL dreq_seq got=%0d exp=1", seq_dreq); end
  endtask

  task automatic test_priority();
    push_key({48'hAABB_CCDD_EEFF, 6'd7});
    pulse_req(1, 1, 0, 1);
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1 || beat[2][15:0] !== 16'h0101 || beat[3][15:0] !== 16'd1) begin n_err++; $display("FAIL prio_first ok=%b msg=%h seq=%0d exp=0101/1", cap_ok, beat[2][15:0], beat[3][15:0]); end
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1 || beat[2][15:0] !== 16'h0301 || beat[3][15:0] !== 16'd1) begin n_err++; $display("FAIL prio_second ok=%b msg=%h seq=%0d exp=0301/1", cap_ok, beat[2][15:0], beat[3][15:0]); end
    n_cmp++; if (beat[0][123:118] !== 6'd7 || beat[2][127:80] !== 48'hAABB_CCDD_EEFF) begin n_err++; $display("FAIL prio_dreq_key port=%0d dst=%h exp=7/aabbccddeeff", beat[0][123:118], beat[2][127:80]); end
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1 || beat[2] !== {6'b110000, 32'h1234_5678, 16'hDDEE, MAC, 16'h88F7, 16'h0501}) begin n_err++; $display("FAIL prio_third_hdr ok=%b got=%h", cap_ok, beat[2]); end
    n_cmp++; if ({beat[0][123:118], beat[3][15:0]} !== 22'd0 || {bstv[5], bvwr[5]} !== 2'b01) begin n_err++; $display("FAIL prio_test_fields port=%0d seq=%0d stv=%b vwr=%b exp=0/0/0/1", beat[0][123:118], beat[3][15:0], bstv[5], bvwr[5]); end
  endtask

  task automatic test_drop();
    int pkts;
    int extra;
    outtx_ready = 1'b0;
    send_sync = 1'b1;
    repeat (9) @(posedge clk);
    #1 send_sync = 1'b0;
    @(negedge clk);
    n_cmp++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
    n_cmp++; if (outtx_data_wr !== 1'b0) begin n_err++; $display("FAIL drop_no_grant got=%b exp=0", outtx_data_wr); end
    @(posedge clk); #1;
    outtx_ready = 1'b1;
    pkts = 0;
    for (int i = 0; i < 9; i++) begin
      cap_pkt();
      if (cap_ok) pkts++;
    end
    n_cmp++; if (pkts != 8) begin n_err++; $display("FAIL drop_pkts got=%0d exp=8", pkts); end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (outtx_data_wr) extra++;
    end
    n_cmp++; if (extra != 0 || seq_sync !== 16'd10) begin n_err++; $display("FAIL drop_after extra=%0d seq=%0d exp=0/10", extra, seq_sync); end
  endtask

  task automatic test_dresp();
    push_key({48'h6655_4433_2211, 6'd5});
    push_t4(48'h0000_0009_0042);
    pulse_req(0, 0, 1, 0);
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1 || beat[2] !== {6'b110000, 48'h6655_4433_2211, MAC, 16'h88F7, 16'h0401}) begin n_err++; $display("FAIL dresp_hdr ok=%b got=%h", cap_ok, beat[2]); end
    n_cmp++; if (beat[5] !== {6'b100100, 32'd0, 48'h0000_0009_0042, 48'd0} || beat[0][123:118] !== 6'd5) begin n_err++; $display("FAIL dresp_tail got=%h port=%0d", beat[5], beat[0][123:118]); end
    n_cmp++; if ({bstv[5], bst[5]} !== {1'b1, 4'd4}) begin n_err++; $display("FAIL dresp_type got=%b/%0d exp=1/4", bstv[5], bst[5]); end
  endtask

  task automatic test_rtt();
`ifdef PTP_TX_RTT_EN
    cyc_timer = {31'd5, 17'd124990};
    pulse_req(1, 0, 0, 0);
    cap_pkt();
    push_key({48'h0000_0000_0001, 6'd1});
    push_t4({31'd6, 17'd10});
    pulse_req(0, 0, 1, 0);
    cap_pkt();
    repeat (2) @(negedge clk);
    n_cmp++; if (rtt_time !== {31'd0, 17'd176}) begin n_err++; $display("FAIL rtt_value got=%h exp=%h", rtt_time, {31'd0, 17'd176}); end
`else
    repeat (2) @(negedge clk);
    n_cmp++; if (rtt_time !== 48'd0) begin n_err++; $display("FAIL rtt_tied got=%h exp=0", rtt_time); end
`endif
  endtask

  task automatic test_reset_midpkt();
    int w;
    int tails;
    cyc_timer = 48'h0000_0001_0001;
    pulse_req(1, 0, 0, 0);
    w = 0;
    @(negedge clk);
    while (!outtx_data_wr && w < 40) begin @(negedge clk); w++; end
    n_cmp++; if (outtx_data_wr !== 1'b1) begin n_err++; $display("FAIL rstmid_start got=%b exp=1", outtx_data_wr); end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (outtx_data_wr !== 1'b0 || outtx_data !== 134'd0) begin n_err++; $display("FAIL rstmid_outputs wr=%b data=%h exp=0", outtx_data_wr, outtx_data); end
    n_cmp++; if ({seq_sync, drop_cnt} !== 32'd0) begin n_err++; $display("FAIL rstmid_counters got=%h exp=0", {seq_sync, drop_cnt}); end
    @(posedge clk); #1;
    rst = 1'b0;
    tails = 0;
    repeat (8) begin
      @(negedge clk);
      if (outtx_valid_wr || outtx_data_wr) tails++;
    end
    n_cmp++; if (tails != 0) begin n_err++; $display("FAIL rstmid_no_tail got=%0d exp=0", tails); end
    pulse_req(1, 0, 0, 0);
    cap_pkt();
    n_cmp++; if (cap_ok !== 1'b1 || beat[3] !== {6'b110000, 16'h0030, 96'd0, 16'd0}) begin n_err++; $display("FAIL rstmid_seq0 ok=%b got=%h", cap_ok, beat[3]); end
  endtask

  initial begin
    rst = 1'b1;
    cyc_timer = '0; mac_addr = MAC;
    send_sync = 0; send_dreq = 0; send_dresp = 0; send_test = 0;
    key = '0; key_valid = 0; ts_4 = '0; ts_4_valid = 0;
    outtx_ready = 1'b1;
    test_reset();
    test_sync();
    test_dreq();
    test_priority();
    test_drop();
    test_dresp();
    test_rtt();
    test_reset_midpkt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
